// File: rtl/counter_mod_adj.sv
// counter_mod_adj: modulo-MOD counter stage for the clock datapath.
// The count advances on a one-cycle tick, can be stepped up/down by
// adjust buttons, and can be parallel-loaded. Wraps produce registered
// one-cycle carry/borrow pulses for cascading the next stage.
// Optional feature macro: COUNTER_MOD_ADJ_AUTOREPEAT_EN adds button
// auto-repeat (hold REPEAT_DELAY cycles, then step every REPEAT_PERIOD).
module counter_mod_adj #(
    parameter int MOD             = 60,
    parameter int W               = 6,
    parameter int CARRY_ON_ADJUST = 0,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         tick,
    input  logic         keep,
    input  logic         adjust,
    input  logic         adj_up,
    input  logic         adj_down,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] digits,
    output logic         carry,
    output logic         borrow,
    output logic         at_zero
);

    if (MOD < 2 || MOD > (1 << W) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("counter_mod_adj: illegal parameter combination");
    end

    localparam int         MAX_I     = MOD - 1;
    localparam logic [W:0] MAX_V     = MAX_I[W:0];
    localparam logic       ADJ_PULSE = (CARRY_ON_ADJUST != 0);

    // Increment modulo MOD, computed one bit wider than the digits.
    function automatic logic [W-1:0] mod_inc(input logic [W-1:0] d);
        logic [W:0] s;
        s = {1'b0, d} + {{W{1'b0}}, 1'b1};
        if ({1'b0, d} == MAX_V) s = '0;
        return s[W-1:0];
    endfunction

    // Decrement modulo MOD; zero wraps to MOD-1.
    function automatic logic [W-1:0] mod_dec(input logic [W-1:0] d);
        logic [W:0] s;
        s = {1'b0, d} - {{W{1'b0}}, 1'b1};
        if (d == '0) s = MAX_V;
        return s[W-1:0];
    endfunction

    // Load values beyond the modulus saturate to MOD-1.
    function automatic logic [W-1:0] sat_load(input logic [W-1:0] v);
        if ({1'b0, v} > MAX_V) return MAX_V[W-1:0];
        return v;
    endfunction

    logic         adj_up_q, adj_down_q;
    logic         up_edge, down_edge;
    logic         rpt_up, rpt_down;
    logic         step_up, step_down;
    logic [W-1:0] digits_nx;
    logic         carry_nx, borrow_nx;

    assign up_edge   = adj_up & ~adj_up_q;
    assign down_edge = adj_down & ~adj_down_q;
    assign at_zero   = (digits == '0);

`ifdef COUNTER_MOD_ADJ_AUTOREPEAT_EN
    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW       = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
    localparam int DL_I     = REPEAT_DELAY - 1;
    localparam int PL_I     = REPEAT_PERIOD - 1;
    localparam logic [CW-1:0] DELAY_LAST  = DL_I[CW-1:0];
    localparam logic [CW-1:0] PERIOD_LAST = PL_I[CW-1:0];

    rpt_state_t    rpt_state, rpt_state_nx;
    logic [CW-1:0] hold_cnt, hold_cnt_nx;
    logic          rpt_dir_up, rpt_dir_up_nx;
    logic          rpt_step, rpt_held, rpt_abort;

    // Auto-repeat state, hold counter and latched button direction.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rpt_state  <= RPT_IDLE;
            hold_cnt   <= '0;
            rpt_dir_up <= 1'b0;
        end else begin
            rpt_state  <= rpt_state_nx;
            hold_cnt   <= hold_cnt_nx;
            rpt_dir_up <= rpt_dir_up_nx;
        end
    end

    // Auto-repeat next state: any release, conflict, mode change or load aborts.
    always_comb begin
        rpt_state_nx  = rpt_state;
        hold_cnt_nx   = hold_cnt;
        rpt_dir_up_nx = rpt_dir_up;
        rpt_step      = 1'b0;
        rpt_held      = rpt_dir_up ? adj_up : adj_down;
        rpt_abort     = load | keep | ~adjust | (adj_up & adj_down) | ~rpt_held;
        case (rpt_state)
            RPT_IDLE: begin
                if (!load && !keep && adjust && (up_edge ^ down_edge)) begin
                    rpt_state_nx  = RPT_DELAY;
                    hold_cnt_nx   = '0;
                    rpt_dir_up_nx = up_edge;
                end
            end
            RPT_DELAY: begin
                if (rpt_abort) begin
                    rpt_state_nx = RPT_IDLE;
                end else if (hold_cnt == DELAY_LAST) begin
                    rpt_step     = 1'b1;
                    rpt_state_nx = RPT_REPEAT;
                    hold_cnt_nx  = '0;
                end else begin
                    hold_cnt_nx = hold_cnt + 1'b1;
                end
            end
            RPT_REPEAT: begin
                if (rpt_abort) begin
                    rpt_state_nx = RPT_IDLE;
                end else if (hold_cnt == PERIOD_LAST) begin
                    rpt_step    = 1'b1;
                    hold_cnt_nx = '0;
                end else begin
                    hold_cnt_nx = hold_cnt + 1'b1;
                end
            end
            default: rpt_state_nx = RPT_IDLE;
        endcase
    end

    assign rpt_up   = rpt_step & rpt_dir_up;
    assign rpt_down = rpt_step & ~rpt_dir_up;
`else
    assign rpt_up   = 1'b0;
    assign rpt_down = 1'b0;
`endif

    // Simultaneous up and down edges cancel each other.
    assign step_up   = adjust & ((up_edge & ~down_edge) | rpt_up);
    assign step_down = adjust & ((down_edge & ~up_edge) | rpt_down);

    // Next count and pulses: load > keep > adjust steps > tick.
    always_comb begin
        digits_nx = digits;
        carry_nx  = 1'b0;
        borrow_nx = 1'b0;
        if (load) begin
            digits_nx = sat_load(load_val);
        end else if (keep) begin
            digits_nx = digits;
        end else if (adjust) begin
            if (step_up && !step_down) begin
                digits_nx = mod_inc(digits);
                carry_nx  = ADJ_PULSE & ({1'b0, digits} == MAX_V);
            end else if (step_down && !step_up) begin
                digits_nx = mod_dec(digits);
                borrow_nx = ADJ_PULSE & (digits == '0);
            end
        end else if (tick) begin
            digits_nx = mod_inc(digits);
            carry_nx  = ({1'b0, digits} == MAX_V);
        end
    end

    // Count register, wrap pulses and button edge-detect history.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            digits     <= '0;
            carry      <= 1'b0;
            borrow     <= 1'b0;
            adj_up_q   <= 1'b0;
            adj_down_q <= 1'b0;
        end else begin
            digits     <= digits_nx;
            carry      <= carry_nx;
            borrow     <= borrow_nx;
            adj_up_q   <= adj_up;
            adj_down_q <= adj_down;
        end
    end

endmodule

// File: tb/tb_counter_mod_adj.sv
// Directed bench for counter_mod_adj: shared stimulus drives a MOD=60
// stage, two MOD=24 stages (adjust carry off/on) and an auto-repeat stage.
module tb_counter_mod_adj;

    logic       clk = 1'b0;
    logic       clear_n, tick, keep, adjust, adj_up, adj_down, load;
    logic [5:0] load_val;

    logic [5:0] d60, dr;
    logic [4:0] d24a, d24b;
    logic       c60, b60, z60, c24a, b24a, z24a, c24b, b24b, z24b, cr, br, zr;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    counter_mod_adj #(.MOD(60), .W(6)) dut60 (
        .clk(clk), .clear_n(clear_n), .tick(tick), .keep(keep), .adjust(adjust),
        .adj_up(adj_up), .adj_down(adj_down), .load(load), .load_val(load_val),
        .digits(d60), .carry(c60), .borrow(b60), .at_zero(z60));

    counter_mod_adj #(.MOD(24), .W(5), .CARRY_ON_ADJUST(0)) dut24a (
        .clk(clk), .clear_n(clear_n), .tick(tick), .keep(keep), .adjust(adjust),
        .adj_up(adj_up), .adj_down(adj_down), .load(load), .load_val(load_val[4:0]),
        .digits(d24a), .carry(c24a), .borrow(b24a), .at_zero(z24a));

    counter_mod_adj #(.MOD(24), .W(5), .CARRY_ON_ADJUST(1)) dut24b (
        .clk(clk), .clear_n(clear_n), .tick(tick), .keep(keep), .adjust(adjust),
        .adj_up(adj_up), .adj_down(adj_down), .load(load), .load_val(load_val[4:0]),
        .digits(d24b), .carry(c24b), .borrow(b24b), .at_zero(z24b));

    counter_mod_adj #(.MOD(60), .W(6), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dutr (
        .clk(clk), .clear_n(clear_n), .tick(tick), .keep(keep), .adjust(adjust),
        .adj_up(adj_up), .adj_down(adj_down), .load(load), .load_val(load_val),
        .digits(dr), .carry(cr), .borrow(br), .at_zero(zr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge: pulse clear_n low between edges.
    task automatic clear_pulse();
        #2 clear_n = 1'b0;
        #2 clear_n = 1'b1;
    endtask

    initial begin
        clear_n = 1'b0; tick = 1'b0; keep = 1'b0; adjust = 1'b0;
        adj_up = 1'b0; adj_down = 1'b0; load = 1'b0; load_val = '0;

        #3;
        check("rst_digits", d60, 0);
        check("rst_carry", c60, 0);
        check("rst_borrow", b60, 0);
        check("rst_at_zero", z60, 1);
        #4 clear_n = 1'b1;

        // 59 ticks then the wrapping 60th
        step();
        tick = 1'b1;
        repeat (59) step();
        check("tick59_digits", d60, 59);
        check("tick59_carry", c60, 0);
        check("tick59_at_zero", z60, 0);
        step();
        check("tick60_digits", d60, 0);
        check("tick60_carry", c60, 1);
        check("tick60_at_zero", z60, 1);
        tick = 1'b0;
        step();
        check("carry_one_cycle", c60, 0);
        check("tick60_hold", d60, 0);

        // adjust-down wrap, carry on adjust off/on
        clear_pulse();
        adjust = 1'b1;
        step();
        adj_down = 1'b1;
        step();
        check("adjdn_d24a", d24a, 23);
        check("adjdn_b24a", b24a, 0);
        check("adjdn_d24b", d24b, 23);
        check("adjdn_b24b", b24b, 1);
        check("adjdn_d60", d60, 59);
        check("adjdn_b60", b60, 0);
        step();
        check("adjdn_held_d24b", d24b, 23);
        check("adjdn_b24b_once", b24b, 0);
        adj_down = 1'b0;
        step();

        // both edges together plus tick: nothing moves
        adj_up = 1'b1; adj_down = 1'b1; tick = 1'b1;
        step();
        check("both_d24a", d24a, 23);
        check("both_d24b", d24b, 23);
        check("both_d60", d60, 59);
        check("both_c24b", c24b, 0);
        check("both_b24b", b24b, 0);
        adj_up = 1'b0; adj_down = 1'b0; tick = 1'b0;
        step();

        // adjust-up wrap
        adj_up = 1'b1;
        step();
        check("adjup_d24a", d24a, 0);
        check("adjup_c24a", c24a, 0);
        check("adjup_z24a", z24a, 1);
        check("adjup_d24b", d24b, 0);
        check("adjup_c24b", c24b, 1);
        check("adjup_z24b", z24b, 1);
        check("adjup_d60", d60, 0);
        check("adjup_c60", c60, 0);

        // edge seen with adjust low is lost
        adj_up = 1'b0; adjust = 1'b0;
        step();
        adj_up = 1'b1;
        step();
        adjust = 1'b1;
        step();
        check("lost_edge_d24a", d24a, 0);
        check("lost_edge_d60", d60, 0);
        adj_up = 1'b0; adjust = 1'b0;
        step();

        // load saturation, load overrides keep, keep blocks tick
        load = 1'b1; load_val = 6'd63;
        step();
        check("load_sat_d60", d60, 59);
        check("load_sat_d24a", d24a, 23);
        keep = 1'b1; load_val = 6'd10;
        step();
        check("load_keep_d60", d60, 10);
        check("load_keep_c60", c60, 0);
        load = 1'b0; tick = 1'b1;
        repeat (3) step();
        check("keep_tick_d60", d60, 10);
        check("keep_tick_c60", c60, 0);
        keep = 1'b0; tick = 1'b0;
        step();

        // async clear mid-count
        clear_pulse();
        tick = 1'b1;
        repeat (37) step();
        check("count37_d60", d60, 37);
        tick = 1'b0;
        #2 clear_n = 1'b0;
        #1;
        check("async_clr_d60", d60, 0);
        check("async_clr_z60", z60, 1);
        check("async_clr_c60", c60, 0);
        #1 clear_n = 1'b1;
        tick = 1'b1;
        step();
        check("after_clr_tick", d60, 1);
        tick = 1'b0;

        // async clear while carry is high
        step();
        load = 1'b1; load_val = 6'd59;
        step();
        load = 1'b0; tick = 1'b1;
        step();
        check("pre_clr_carry", c60, 1);
        tick = 1'b0;
        #2 clear_n = 1'b0;
        #1;
        check("clr_drops_carry", c60, 0);
        #1 clear_n = 1'b1;
        step();

        // hold adj_up 20 cycles on the auto-repeat stage
        clear_pulse();
        adjust = 1'b1;
        step();
        adj_up = 1'b1;
        step();
        check("rpt_first_edge", dr, 1);
        repeat (7) step();
        check("rpt_before_delay", dr, 1);
        step();
`ifdef COUNTER_MOD_ADJ_AUTOREPEAT_EN
        check("rpt_after_delay", dr, 2);
`else
        check("rpt_after_delay", dr, 1);
`endif
        repeat (11) step();
`ifdef COUNTER_MOD_ADJ_AUTOREPEAT_EN
        check("rpt_held20", dr, 5);
`else
        check("rpt_held20", dr, 1);
`endif
        adj_up = 1'b0;
        repeat (10) step();
`ifdef COUNTER_MOD_ADJ_AUTOREPEAT_EN
        check("rpt_released", dr, 5);
`else
        check("rpt_released", dr, 1);
`endif
        check("rpt_carry", cr, 0);
        check("rpt_borrow", br, 0);
        check("rpt_at_zero", zr, 0);
        adjust = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
